// File: rtl/master_tx_ltssm_if.sv
// Ordered-set request channel between the LTSSM TX sequencer and the OS generator.
// Carries the current substate in, and OS selection / PHY control / completion out.
interface master_tx_ltssm_if;
    logic [3:0] substate;
    logic       osReady;
    logic       osValid;
    logic [2:0] osType;
    logic       txElectricalIdle;
    logic       disableScrambler;
    logic       finish;
    logic [3:0] exitTo;

    modport master (
        input  substate, osReady,
        output osValid, osType, txElectricalIdle, disableScrambler, finish, exitTo
    );

    modport slave (
        output substate, osReady,
        input  osValid, osType, txElectricalIdle, disableScrambler, finish, exitTo
    );
endinterface

// File: rtl/master_tx_ltssm.sv
// TX side of the LTSSM: streams the ordered sets each substate needs and pulses finish.
// Optional MASTER_TX_EIOS_EN sends one EIOS before falling back to detectQuiet.
module master_tx_ltssm #(
    parameter int POLL_TS_COUNT = 1024,
    parameter int CFG_OS_COUNT  = 16
) (
    input  logic               clk,
    input  logic               reset,
    master_tx_ltssm_if.master  bus
);
    typedef enum logic [1:0] {START, SEND, HOLD, DONE} state_t;

    localparam logic [2:0]  OS_NONE  = 3'd0;
    localparam logic [2:0]  OS_TS1   = 3'd1;
    localparam logic [2:0]  OS_TS2   = 3'd2;
    localparam logic [2:0]  OS_IDLE  = 3'd3;
    localparam logic [10:0] POLL_TGT = 11'(POLL_TS_COUNT);
    localparam logic [10:0] CFG_TGT  = 11'(CFG_OS_COUNT);

    state_t      state, state_nxt;
    logic [3:0]  last_served, last_nxt;
    logic [3:0]  cur_sub, cur_nxt;
    logic [10:0] sent_cnt, cnt_nxt;
    logic [10:0] target, tgt_nxt;
    logic [2:0]  os_type, type_nxt;
    logic        elec_idle, ei_nxt;
    logic        scr_off, scr_nxt;
    logic        os_valid, fin;
    logic [3:0]  exit_to;
`ifdef MASTER_TX_EIOS_EN
    localparam logic [2:0] OS_EIOS = 3'd4;
    logic        eios_pend, eios_nxt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= START;
            last_served <= 4'hF;
            cur_sub     <= 4'hF;
            sent_cnt    <= '0;
            target      <= '0;
            os_type     <= OS_NONE;
            elec_idle   <= 1'b1;
            scr_off     <= 1'b1;
`ifdef MASTER_TX_EIOS_EN
            eios_pend   <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            last_served <= last_nxt;
            cur_sub     <= cur_nxt;
            sent_cnt    <= cnt_nxt;
            target      <= tgt_nxt;
            os_type     <= type_nxt;
            elec_idle   <= ei_nxt;
            scr_off     <= scr_nxt;
`ifdef MASTER_TX_EIOS_EN
            eios_pend   <= eios_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last_served;
        cur_nxt   = cur_sub;
        cnt_nxt   = sent_cnt;
        tgt_nxt   = target;
        type_nxt  = os_type;
        ei_nxt    = elec_idle;
        scr_nxt   = scr_off;
        os_valid  = 1'b0;
        fin       = 1'b0;
        exit_to   = 4'd0;
`ifdef MASTER_TX_EIOS_EN
        eios_nxt  = eios_pend;
`endif
        case (state)
            START: begin
                if (bus.substate > 4'd9) begin
                    type_nxt = OS_NONE;
                    ei_nxt   = 1'b1;
                    scr_nxt  = 1'b1;
                end else if (bus.substate != last_served) begin
                    state_nxt = SEND;
                    cur_nxt   = bus.substate;
                    cnt_nxt   = '0;
                    ei_nxt    = 1'b0;
                    scr_nxt   = 1'b1;
                    tgt_nxt   = CFG_TGT;
                    case (bus.substate)
                        4'd0, 4'd1: begin type_nxt = OS_NONE; ei_nxt = 1'b1; tgt_nxt = '0; end
                        4'd2:       begin type_nxt = OS_TS1;  tgt_nxt = POLL_TGT; end
                        4'd3:       type_nxt = OS_TS2;
                        4'd8:       begin type_nxt = OS_TS2;  scr_nxt = 1'b0; end
                        4'd9:       begin type_nxt = OS_IDLE; scr_nxt = 1'b0; end
                        default:    type_nxt = OS_TS1;
                    endcase
`ifdef MASTER_TX_EIOS_EN
                    // Leaving an active substate for detectQuiet: close the link with one EIOS first.
                    if (bus.substate == 4'd0 && cur_sub >= 4'd2 && cur_sub <= 4'd9) begin
                        type_nxt = OS_EIOS;
                        ei_nxt   = 1'b0;
                        tgt_nxt  = 11'd1;
                        eios_nxt = 1'b1;
                    end
`endif
                end
            end
            SEND: begin
                os_valid = (target != '0);
                if (bus.substate != cur_sub) begin
                    state_nxt = START;
`ifdef MASTER_TX_EIOS_EN
                    eios_nxt  = 1'b0;
`endif
                end else if (target == '0) begin
                    state_nxt = DONE;
                end else if (bus.osReady) begin
                    cnt_nxt = (sent_cnt == 11'h7FF) ? sent_cnt : sent_cnt + 11'd1;
`ifdef MASTER_TX_EIOS_EN
                    if (eios_pend) begin
                        // EIOS accepted: go quiet, then finish as a zero-count substate.
                        eios_nxt = 1'b0;
                        type_nxt = OS_NONE;
                        ei_nxt   = 1'b1;
                        tgt_nxt  = '0;
                        cnt_nxt  = '0;
                    end else
`endif
                    if ({1'b0, sent_cnt} + 12'd1 >= {1'b0, target})
                        state_nxt = DONE;
                end
            end
            DONE: begin
                fin       = 1'b1;
                exit_to   = cur_sub + 4'd1;
                last_nxt  = cur_sub;
                state_nxt = HOLD;
            end
            default: begin
                os_valid = (os_type != OS_NONE);
                if (bus.substate != last_served)
                    state_nxt = START;
            end
        endcase
    end

    assign bus.osValid          = os_valid;
    assign bus.osType           = os_type;
    assign bus.txElectricalIdle = elec_idle;
    assign bus.disableScrambler = scr_off;
    assign bus.finish           = fin;
    assign bus.exitTo           = exit_to;
endmodule

// File: doc/master_tx_ltssm.md
MASTER_TX_LTSSM -- requirements
Module: master_tx_ltssm

Interface
- REQ-001 SHALL declare parameter: POLL_TS_COUNT, 1024, TS1 ordered sets sent in pollingActive before finish.
- REQ-002 SHALL declare parameter: CFG_OS_COUNT, 16, ordered sets sent in every other transmitting substate before finish.
- REQ-003 SHALL declare port: clk  input  1  single clock; all logic on its rising edge.
- REQ-004 SHALL declare port: reset  input  1  asynchronous, active-low reset.
- REQ-005 SHALL declare port: substate  input  4  substate from main LTSSM (0 detectQuiet .. 9 configurationIdle).
- REQ-006 SHALL declare port: osReady  input  1  ordered-set generator accepts current OS this cycle.
- REQ-007 SHALL declare port: osValid  output  1  osType is valid for transmission.
- REQ-008 SHALL declare port: osType  output  3  0 none, 1 TS1, 2 TS2, 3 IDLE, 4 EIOS.
- REQ-009 SHALL declare port: txElectricalIdle  output  1  drive transmitter to electrical idle.
- REQ-010 SHALL declare port: disableScrambler  output  1  bypass TX scrambler.
- REQ-011 SHALL declare port: finish  output  1  one-cycle pulse: substate requirement met.
- REQ-012 SHALL declare port: exitTo  output  4  next substate, valid while finish=1.

Function
- REQ-013 SHALL implement FSM states START, SEND, HOLD, DONE.
- REQ-014 START: on substate != lastServed (register, reset value 4'hF), load OS type and target count per substate, clear sentCount, go to SEND; otherwise remain, osValid=0.
- REQ-015 Substate mapping: detectQuiet/detectActive -> osType=0, txElectricalIdle=1, target 0; pollingActive -> TS1, POLL_TS_COUNT; pollingConfiguration -> TS2, CFG_OS_COUNT; configurationLinkWidthStart/LinkWidthAccept/LanenumWait/LanenumAccept -> TS1, CFG_OS_COUNT; configurationComplete -> TS2, CFG_OS_COUNT; configurationIdle -> IDLE, CFG_OS_COUNT.
- REQ-016 substate 10..15: remain in START, no finish, outputs at reset values.
- REQ-017 SEND: osValid=1; sentCount (11 bits, saturating) increments only when osValid&&osReady; osType stable while osReady=0.
- REQ-018 SEND -> DONE in the cycle after sentCount reaches target; target 0 goes to DONE on the next cycle.
- REQ-019 DONE: finish=1 for exactly one cycle, exitTo=substate+1 (configurationIdle -> 4'd10), lastServed<=substate, then HOLD.
- REQ-020 HOLD: keep sending same osType (osValid=1) until substate changes, then START; count not checked.
- REQ-021 substate change during SEND: abort to START in next cycle, no finish, count discarded.
- REQ-022 disableScrambler=0 only for configurationIdle IDLE data and configurationComplete TS2, else 1.
- REQ-023 finish and a new-substate START evaluation never coincide; latency substate change -> osValid = 2 cycles.

Reset
- REQ-024 While reset=0: state START, lastServed=4'hF, sentCount=0, osValid=0, osType=0, txElectricalIdle=1, disableScrambler=1, finish=0, exitTo=0.
- REQ-025 Reset asserted mid-SEND SHALL abort immediately without finish; after release the current substate is served as new.

Configuration
- REQ-026 Macro MASTER_TX_EIOS_EN: when defined, a transition from any substate >=2 to detectQuiet SHALL first send one EIOS (osType=4, handshaked) before asserting txElectricalIdle; when undefined, txElectricalIdle asserts directly in START with no EIOS.

Verification
- REQ-027 Reset release, substate=0 -> txElectricalIdle=1, finish pulse within 3 cycles, exitTo=1.
- REQ-028 substate=2, osReady=1 always -> exactly 1024 TS1 handshakes, finish=1 one cycle, exitTo=3, TS1 continues in HOLD.
- REQ-029 substate=4, osReady toggling 50% -> osType=1 held stable while osReady=0; finish after 16th handshake.
- REQ-030 substate=2 then 4 after 100 handshakes -> no finish, restart count, finish after 16 TS1.
- REQ-031 substate=9 -> osType=3, disableScrambler=0, finish after 16, exitTo=10.
- REQ-032 With MASTER_TX_EIOS_EN, substate 5 -> 0 -> one osType=4 handshake, then txElectricalIdle=1; without it, no EIOS.
